sync_timing_gen: RTL and testbench

// - Video timing generator: produces hsync/vsync/de and pixel/line counters from the captured timing SFRs.
// - Drives i_vsync_sync of the SFR capture block, which latches the next frame's SFRs on each vsync rise.
// - Holds a private shadow of the timing parameters; it only reloads that shadow on a frame boundary,
//   so an SFR change never causes a torn frame.

---
 rtl/tg_pkg.sv | 28 ++
 rtl/tg_axis_cnt.sv | 57 +++++
 rtl/sync_timing_gen.sv | 130 +++++++++++++
 tb/tb_sync_timing_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tg_pkg.sv
// Shared types and helpers for the video timing generator: axis timing record,
// FSM state encoding and the total-vs-fields consistency check.
package tg_pkg;

    localparam int TG_PW = 16;

    typedef struct packed {
        logic [TG_PW-1:0] sw;
        logic [TG_PW-1:0] bp;
        logic [TG_PW-1:0] act;
        logic [TG_PW-1:0] fp;
        logic [TG_PW-1:0] total;
    } tg_axis_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tg_state_e;

    // Two extra bits keep the field sum from overflowing; an all-zero record wraps to all ones and mismatches.
    function automatic logic tg_total_bad(input tg_axis_t a);
        logic [TG_PW+1:0] sum;
        sum = {2'b00, a.sw} + {2'b00, a.bp} + {2'b00, a.act} + {2'b00, a.fp}
            - {{(TG_PW+1){1'b0}}, 1'b1};
        return sum != {2'b00, a.total};
    endfunction

endpackage

// File: rtl/tg_axis_cnt.sv
// One timing axis: position counter with clear/increment/wrap plus sync, active-window
// and wrap decode against that axis' shadowed timing record.
module tg_axis_cnt
    import tg_pkg::*;
(
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             clear,
    input  logic             inc,
    input  tg_axis_t         cfg,
    output logic [TG_PW-1:0] cnt,
    output logic             sync,
    output logic             active,
    output logic             wrap,
    output logic             cfg_bad
);

    localparam logic [TG_PW-1:0] CNT_ONE = TG_PW'(1);

    logic [TG_PW-1:0] cnt_reg;
    logic [TG_PW-1:0] cnt_next;
    logic [TG_PW+1:0] cnt_ext;
    logic [TG_PW+1:0] act_lo;
    logic [TG_PW+1:0] act_hi;
    logic             at_total;

    // >= rather than == so a count can never run past its total.
    assign at_total = (cnt_reg >= cfg.total);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = at_total ? '0 : cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_ext = {2'b00, cnt_reg};
    assign act_lo  = {2'b00, cfg.sw} + {2'b00, cfg.bp};
    assign act_hi  = act_lo + {2'b00, cfg.act};

    assign cnt     = cnt_reg;
    assign sync    = (cnt_reg < cfg.sw);
    assign active  = (cnt_ext >= act_lo) && (cnt_ext < act_hi);
    assign wrap    = inc && at_total && !clear;
    assign cfg_bad = tg_total_bad(cfg);

endmodule

// File: rtl/sync_timing_gen.sv
// Video timing generator: run/idle FSM, frame-boundary shadowing of the timing SFRs,
// sticky configuration error and registered, mutually aligned sync/de/counter outputs.
module sync_timing_gen
    import tg_pkg::*;
#(
    parameter int PARAM_WIDTH = TG_PW
)
(
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   i_en,
    input  logic [PARAM_WIDTH-1:0] i_hsw,
    input  logic [PARAM_WIDTH-1:0] i_hbp,
    input  logic [PARAM_WIDTH-1:0] i_hact,
    input  logic [PARAM_WIDTH-1:0] i_hfp,
    input  logic [PARAM_WIDTH-1:0] i_htotal,
    input  logic [PARAM_WIDTH-1:0] i_vsw,
    input  logic [PARAM_WIDTH-1:0] i_vbp,
    input  logic [PARAM_WIDTH-1:0] i_vact,
    input  logic [PARAM_WIDTH-1:0] i_vfp,
    input  logic [PARAM_WIDTH-1:0] i_vtotal,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [PARAM_WIDTH-1:0] o_hcnt,
    output logic [PARAM_WIDTH-1:0] o_vcnt,
    output logic                   o_line_start,
    output logic                   o_frame_start,
    output logic                   o_cfg_err
);

    tg_state_e        state_reg;
    tg_axis_t         h_sfr;
    tg_axis_t         v_sfr;
    tg_axis_t         h_shadow_reg;
    tg_axis_t         v_shadow_reg;
    logic             shadow_ld_d_reg;
    logic             run;
    logic             shadow_ld;
    logic [TG_PW-1:0] hcnt;
    logic [TG_PW-1:0] vcnt;
    logic             h_sync, h_act, h_wrap, h_bad;
    logic             v_sync, v_act, v_wrap, v_bad;

    assign h_sfr = '{sw: i_hsw, bp: i_hbp, act: i_hact, fp: i_hfp, total: i_htotal};
    assign v_sfr = '{sw: i_vsw, bp: i_vbp, act: i_vact, fp: i_vfp, total: i_vtotal};

    // Dropping i_en takes effect on the very next edge, even mid-frame.
    assign run = (state_reg == ST_RUN) && i_en;
    // The v axis only wraps on the last pixel of the frame, which is the in-run reload point.
    assign shadow_ld = (state_reg == ST_IDLE) || v_wrap;

    tg_axis_cnt u_h_axis (
        .I_CLK   (I_CLK),
        .I_RST   (I_RST),
        .clear   (!run),
        .inc     (run),
        .cfg     (h_shadow_reg),
        .cnt     (hcnt),
        .sync    (h_sync),
        .active  (h_act),
        .wrap    (h_wrap),
        .cfg_bad (h_bad)
    );

    tg_axis_cnt u_v_axis (
        .I_CLK   (I_CLK),
        .I_RST   (I_RST),
        .clear   (!run),
        .inc     (h_wrap),
        .cfg     (v_shadow_reg),
        .cnt     (vcnt),
        .sync    (v_sync),
        .active  (v_act),
        .wrap    (v_wrap),
        .cfg_bad (v_bad)
    );

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_reg       <= ST_IDLE;
            h_shadow_reg    <= '0;
            v_shadow_reg    <= '0;
            shadow_ld_d_reg <= 1'b0;
            o_cfg_err       <= 1'b0;
            o_hsync         <= 1'b0;
            o_vsync         <= 1'b0;
            o_de            <= 1'b0;
            o_hcnt          <= '0;
            o_vcnt          <= '0;
            o_line_start    <= 1'b0;
            o_frame_start   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (i_en)  state_reg <= ST_RUN;
                ST_RUN:  if (!i_en) state_reg <= ST_IDLE;
                default:            state_reg <= ST_IDLE;
            endcase

            shadow_ld_d_reg <= shadow_ld;
            if (shadow_ld) begin
                h_shadow_reg <= h_sfr;
                v_shadow_reg <= v_sfr;
            end
            // Judged on the freshly latched shadow, so the reset-zero shadow never raises it.
            if (shadow_ld_d_reg && (h_bad || v_bad)) begin
                o_cfg_err <= 1'b1;
            end

            if (run) begin
                o_hsync       <= h_sync;
                o_vsync       <= v_sync;
                o_de          <= h_act && v_act;
                o_hcnt        <= hcnt;
                o_vcnt        <= vcnt;
                o_line_start  <= (hcnt == '0);
                o_frame_start <= (hcnt == '0) && (vcnt == '0);
            end else begin
                o_hsync       <= 1'b0;
                o_vsync       <= 1'b0;
                o_de          <= 1'b0;
                o_hcnt        <= '0;
                o_vcnt        <= '0;
                o_line_start  <= 1'b0;
                o_frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_timing_gen.sv
// Directed bench for sync_timing_gen: a table of hand-computed output vectors for the
// T1 timing and a mid-frame SFR change, then hand sequences for the multi-cycle corner cases.
module tb_sync_timing_gen;
    import tg_pkg::*;

    logic        I_CLK = 1'b0;
    logic        I_RST;
    logic        i_en;
    logic [15:0] i_hsw, i_hbp, i_hact, i_hfp, i_htotal;
    logic [15:0] i_vsw, i_vbp, i_vact, i_vfp, i_vtotal;
    logic        o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_cfg_err;
    logic [15:0] o_hcnt, o_vcnt;

    int n_vec = 0;
    int n_err = 0;
    int cur_k;

    sync_timing_gen #(.PARAM_WIDTH(16)) dut (
        .I_CLK         (I_CLK),
        .I_RST         (I_RST),
        .i_en          (i_en),
        .i_hsw         (i_hsw),
        .i_hbp         (i_hbp),
        .i_hact        (i_hact),
        .i_hfp         (i_hfp),
        .i_htotal      (i_htotal),
        .i_vsw         (i_vsw),
        .i_vbp         (i_vbp),
        .i_vact        (i_vact),
        .i_vfp         (i_vfp),
        .i_vtotal      (i_vtotal),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_de          (o_de),
        .o_hcnt        (o_hcnt),
        .o_vcnt        (o_vcnt),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start),
        .o_cfg_err     (o_cfg_err)
    );

    always #5 I_CLK = ~I_CLK;

    // flags = {hsync, vsync, de, line_start, frame_start}; k = output index since the first counted pixel
    typedef struct {
        int         k;
        int         cfg;
        logic [4:0] flags;
        int         hc;
        int         vc;
    } vec_t;

    vec_t vecs[$];

    // 0: T1   1: T1 with hact16/htot22   2: hbp0 hfp0 hact0 htot1   3: T1 with htot20
    task automatic set_cfg(input int sel);
        i_hsw = 2; i_hbp = 3; i_hact = 8; i_hfp = 2; i_htotal = 14;
        i_vsw = 1; i_vbp = 2; i_vact = 4; i_vfp = 1; i_vtotal = 7;
        case (sel)
            1: begin i_hact = 16; i_htotal = 22; end
            2: begin i_hbp = 0; i_hfp = 0; i_hact = 0; i_htotal = 1; end
            3: i_htotal = 20;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge I_CLK);
        #1;
        cur_k++;
    endtask

    task automatic check(input string name, input int k, input logic [4:0] fl,
                         input int hc, input int vc);
        logic [4:0] got;
        got = {o_hsync, o_vsync, o_de, o_line_start, o_frame_start};
        n_vec++;
        if (got !== fl || o_hcnt !== 16'(hc) || o_vcnt !== 16'(vc)) begin
            n_err++;
            $display("FAIL %s k=%0d: got flags=%b h=%0d v=%0d, expected flags=%b h=%0d v=%0d",
                     name, k, got, o_hcnt, o_vcnt, fl, hc, vc);
        end else begin
            $display("ok   %s k=%0d flags=%b h=%0d v=%0d", name, k, got, o_hcnt, o_vcnt);
        end
    endtask

    task automatic check_err(input string name, input logic exp);
        n_vec++;
        if (o_cfg_err !== exp) begin
            n_err++;
            $display("FAIL %s: got cfg_err=%b, expected %b", name, o_cfg_err, exp);
        end else begin
            $display("ok   %s cfg_err=%b", name, o_cfg_err);
        end
    endtask

    initial begin
        vec_t v;
        bit   found;

        // T1: 15-pixel lines, 8 lines, 120-cycle frames
        vecs.push_back('{  0, 0, 5'b11011,  0, 0});
        vecs.push_back('{  1, 0, 5'b11000,  1, 0});
        vecs.push_back('{  2, 0, 5'b01000,  2, 0});
        vecs.push_back('{ 15, 0, 5'b10010,  0, 1});
        vecs.push_back('{ 49, 0, 5'b00000,  4, 3});
        vecs.push_back('{ 50, 0, 5'b00100,  5, 3});
        vecs.push_back('{ 57, 0, 5'b00100, 12, 3});
        vecs.push_back('{ 58, 0, 5'b00000, 13, 3});
        vecs.push_back('{102, 0, 5'b00100, 12, 6});
        vecs.push_back('{110, 0, 5'b00000,  5, 7});
        vecs.push_back('{119, 0, 5'b00000, 14, 7});
        vecs.push_back('{120, 0, 5'b11011,  0, 0});
        vecs.push_back('{240, 0, 5'b11011,  0, 0});
        // SFRs switch to hact16/htot22 mid frame 2; frame 2 keeps 15-pixel lines
        vecs.push_back('{250, 1, 5'b01000, 10, 0});
        vecs.push_back('{255, 1, 5'b10010,  0, 1});
        vecs.push_back('{359, 1, 5'b00000, 14, 7});
        // frame 3 onwards: 23-pixel lines, 184-cycle frames, de on hcnt 5..20
        vecs.push_back('{360, 1, 5'b11011,  0, 0});
        vecs.push_back('{374, 1, 5'b01000, 14, 0});
        vecs.push_back('{382, 1, 5'b01000, 22, 0});
        vecs.push_back('{383, 1, 5'b10010,  0, 1});
        vecs.push_back('{449, 1, 5'b00100, 20, 3});
        vecs.push_back('{450, 1, 5'b00000, 21, 3});
        vecs.push_back('{544, 1, 5'b11011,  0, 0});

        I_RST = 1'b1;
        i_en  = 1'b0;
        set_cfg(0);
        cur_k = 0;
        repeat (3) @(posedge I_CLK);
        #1;
        check("reset_held", 0, 5'b00000, 0, 0);
        I_RST = 1'b0;
        step();
        check("idle_after_reset", 0, 5'b00000, 0, 0);
        check_err("idle_err", 1'b0);

        i_en = 1'b1;
        step();
        check("en_first_edge", 0, 5'b00000, 0, 0);

        cur_k = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            set_cfg(v.cfg);
            while (cur_k < v.k) step();
            check("table", v.k, v.flags, v.hc, v.vc);
        end
        check_err("t1_err", 1'b0);

        // Drop i_en while the counters hold hcnt6/vcnt4 (outputs lag by one: 5/4)
        set_cfg(0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (o_hcnt == 16'd5 && o_vcnt == 16'd4) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL find_h6v4: got no hcnt5/vcnt4 output within 400 cycles, expected one");
        end
        i_en = 1'b0;
        step();
        check("en_drop", 0, 5'b00000, 0, 0);
        step();
        check("idle_hold", 0, 5'b00000, 0, 0);
        i_en = 1'b1;
        step();
        check("reen_edge1", 0, 5'b00000, 0, 0);
        step();
        check("reen_edge2", 0, 5'b11011, 0, 0);

        // Degenerate horizontal timing: two-pixel lines, empty active window
        i_en = 1'b0;
        set_cfg(2);
        step();
        step();
        i_en = 1'b1;
        step();
        cur_k = -1;
        for (int k = 0; k < 24; k++) begin
            int hc, vc;
            step();
            hc = k % 2;
            vc = (k / 2) % 8;
            check("degen", k, {1'b1, vc == 0, 1'b0, hc == 0, hc == 0 && vc == 0}, hc, vc);
        end
        check_err("degen_err", 1'b0);

        // Inconsistent htotal: flag sets after the load and stays set
        i_en = 1'b0;
        set_cfg(3);
        repeat (3) step();
        check_err("bad_total_err", 1'b1);
        set_cfg(0);
        i_en = 1'b1;
        repeat (30) step();
        check_err("err_sticky", 1'b1);

        // Asynchronous reset mid-line
        #3;
        I_RST = 1'b1;
        #1;
        check("async_reset", 0, 5'b00000, 0, 0);
        check_err("async_reset_err", 1'b0);
        i_en = 1'b0;
        #2;
        I_RST = 1'b0;
        repeat (5) step();
        check("post_reset_idle", 0, 5'b00000, 0, 0);
        i_en = 1'b1;
        step();
        check("restart_edge1", 0, 5'b00000, 0, 0);
        step();
        check("restart_edge2", 0, 5'b11011, 0, 0);
        check_err("restart_err", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
